// File: rtl/tile_pkg.sv
// Shared constants and types for the tile map write engine.
package tile_pkg;

   localparam int unsigned TILE_COLS   = 80;
   localparam int unsigned TILE_ROWS   = 60;
   localparam int unsigned NUM_TILES   = TILE_COLS * TILE_ROWS;
   localparam int unsigned MAX_TILE_ID = 40;

   typedef logic [5:0]  tile_id_t;
   typedef logic [12:0] tile_addr_t;

   localparam logic [1:0] REG_CURSOR = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_FILL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

endpackage

// File: rtl/tile_fill_engine.sv
// Bulk fill engine: writes one tile ID to every map entry, one write per cycle.
module tile_fill_engine #(
   parameter int unsigned NUM_TILES = tile_pkg::NUM_TILES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [5:0]  id,
   output logic        we,
   output logic [12:0] addr,
   output logic [5:0]  data,
   output logic        busy
);
   import tile_pkg::*;

   localparam tile_addr_t LAST_ADDR = tile_addr_t'(NUM_TILES - 1);

   fill_state_t state_q, state_d;
   logic        we_q, we_d;
   tile_addr_t  addr_q, addr_d;
   tile_id_t    data_q, data_d;

   // Next-state and write-port sequencing for the fill sweep.
   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               we_d    = 1'b1;
               addr_d  = '0;
               data_d  = id;
            end
         end
         FILL: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               we_d   = 1'b1;
               addr_d = addr_q + 13'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign we   = we_q;
   assign addr = addr_q;
   assign data = data_q;
   assign busy = (state_q != IDLE);

endmodule

// File: rtl/tile_map_writer.sv
// Avalon-MM slave that writes the tile map RAM via a cursor or a bulk fill.
module tile_map_writer #(
   parameter int unsigned NUM_TILES   = tile_pkg::NUM_TILES,
   parameter int unsigned MAX_TILE_ID = tile_pkg::MAX_TILE_ID
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [1:0]  address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        tile_we,
   output logic [12:0] tile_waddr,
   output logic [5:0]  tile_wdata,
   output logic        busy
);
   import tile_pkg::*;

   localparam tile_addr_t LAST_ADDR = tile_addr_t'(NUM_TILES - 1);
   localparam tile_id_t   MAX_ID    = tile_id_t'(MAX_TILE_ID);

   tile_addr_t  cursor_q, cursor_d;
   logic        err_id_q, err_id_d;
   logic        err_addr_q, err_addr_d;
   logic        err_busy_q, err_busy_d;
   tile_id_t    last_fill_q, last_fill_d;
   logic [15:0] readdata_q, readdata_d;
   logic        sw_we_q, sw_we_d;
   tile_addr_t  sw_addr_q, sw_addr_d;
   tile_id_t    sw_data_q, sw_data_d;

   logic        fill_start;
   logic        fe_we, fe_busy;
   tile_addr_t  fe_addr;
   tile_id_t    fe_data;

   logic        wr, rd;
   logic        set_id, set_addr, set_busy;
   tile_id_t    wd_id;

   assign wr    = chipselect & write;
   assign rd    = chipselect & read;
   assign wd_id = writedata[5:0];

   tile_fill_engine #(
      .NUM_TILES (NUM_TILES)
   ) u_fill (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (fill_start),
      .id      (wd_id),
      .we      (fe_we),
      .addr    (fe_addr),
      .data    (fe_data),
      .busy    (fe_busy)
   );

   // Register-write decode, error flags and read mux.
   always_comb begin
      cursor_d    = cursor_q;
      err_id_d    = err_id_q;
      err_addr_d  = err_addr_q;
      err_busy_d  = err_busy_q;
      last_fill_d = last_fill_q;
      readdata_d  = readdata_q;
      sw_we_d     = 1'b0;
      sw_addr_d   = sw_addr_q;
      sw_data_d   = sw_data_q;
      fill_start  = 1'b0;
      set_id      = 1'b0;
      set_addr    = 1'b0;
      set_busy    = 1'b0;

      if (wr) begin
         case (address)
            REG_CURSOR: begin
               if (fe_busy)                          set_busy = 1'b1;
               else if (writedata > 16'(LAST_ADDR))  set_addr = 1'b1;
               else                                  cursor_d = writedata[12:0];
            end
            REG_DATA: begin
               if (fe_busy)              set_busy = 1'b1;
               else if (wd_id > MAX_ID)  set_id   = 1'b1;
               else begin
                  sw_we_d   = 1'b1;
                  sw_addr_d = cursor_q;
                  sw_data_d = wd_id;
                  cursor_d  = (cursor_q == LAST_ADDR) ? '0 : cursor_q + 13'd1;
               end
            end
            REG_FILL: begin
               if (fe_busy)              set_busy = 1'b1;
               else if (wd_id > MAX_ID)  set_id   = 1'b1;
               else begin
                  fill_start  = 1'b1;
                  last_fill_d = wd_id;
               end
            end
            default: begin
               if (writedata[1]) err_id_d   = 1'b0;
               if (writedata[2]) err_addr_d = 1'b0;
               if (writedata[3]) err_busy_d = 1'b0;
            end
         endcase
      end

      // Sets are applied after the clears so a same-cycle error wins.
      if (set_id)   err_id_d   = 1'b1;
      if (set_addr) err_addr_d = 1'b1;
      if (set_busy) err_busy_d = 1'b1;

      if (rd) begin
         case (address)
            REG_CURSOR: readdata_d = {3'b000, cursor_q};
            REG_FILL:   readdata_d = {10'd0, last_fill_q};
            REG_STATUS: readdata_d = {12'd0, err_busy_q, err_addr_q, err_id_q, fe_busy};
            default:    readdata_d = '0;
         endcase
      end
   end

   // Register file, single-write port and read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cursor_q    <= '0;
         err_id_q    <= 1'b0;
         err_addr_q  <= 1'b0;
         err_busy_q  <= 1'b0;
         last_fill_q <= '0;
         readdata_q  <= '0;
         sw_we_q     <= 1'b0;
         sw_addr_q   <= '0;
         sw_data_q   <= '0;
      end else begin
         cursor_q    <= cursor_d;
         err_id_q    <= err_id_d;
         err_addr_q  <= err_addr_d;
         err_busy_q  <= err_busy_d;
         last_fill_q <= last_fill_d;
         readdata_q  <= readdata_d;
         sw_we_q     <= sw_we_d;
         sw_addr_q   <= sw_addr_d;
         sw_data_q   <= sw_data_d;
      end
   end

   // Both write sources are flops; single writes are only accepted while the
   // engine is idle, so the two enables never overlap and a plain OR/mux suffices.
   assign tile_we    = fe_we | sw_we_q;
   assign tile_waddr = fe_we ? fe_addr : sw_addr_q;
   assign tile_wdata = fe_we ? fe_data : sw_data_q;
   assign readdata   = readdata_q;
   assign busy       = fe_busy;

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer with a cycle-tagged write scoreboard.
module tb_tile_map_writer;

   typedef struct {
      int          cyc;
      logic [12:0] addr;
      logic [5:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [1:0]  address = 2'd0;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        tile_we;
   logic [12:0] tile_waddr;
   logic [5:0]  tile_wdata;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   wr_t exp_q[$];

   tile_map_writer #(
      .NUM_TILES   (4800),
      .MAX_TILE_ID (40)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .tile_we    (tile_we),
      .tile_waddr (tile_waddr),
      .tile_wdata (tile_wdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compare every RAM write against the expected queue; flag late or missing writes.
   always @(negedge clk) begin
      if (reset_n) begin
         if (tile_we) begin
            if (exp_q.size() == 0) begin
               check("spurious_we", {31'd0, tile_we}, 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_cycle", cyc, e.cyc);
               check("wr_addr", {19'd0, tile_waddr}, {19'd0, e.addr});
               check("wr_data", {26'd0, tile_wdata}, {26'd0, e.data});
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            void'(exp_q.pop_front());
            check("missing_we", {31'd0, tile_we}, 32'd1);
         end
      end
   end

   task automatic push_wr(input int c, input logic [12:0] a, input logic [5:0] d);
      wr_t e;
      e.cyc = c; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] rd;
      int k;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_readdata", {16'd0, readdata}, 32'd0);
      check("rst_tile_we", {31'd0, tile_we}, 32'd0);
      check("rst_waddr", {19'd0, tile_waddr}, 32'd0);
      check("rst_wdata", {26'd0, tile_wdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Cursor writes and back-to-back DATA writes
      bus_write(2'd0, 16'd100);
      push_wr(cyc + 1, 13'd100, 6'd12);
      bus_write(2'd1, 16'd12);
      push_wr(cyc + 1, 13'd101, 6'd7);
      bus_write(2'd1, 16'd7);
      bus_read(2'd0, rd);
      check("cursor_102", {16'd0, rd}, 32'd102);

      // Wrap at the last entry
      bus_write(2'd0, 16'd4799);
      push_wr(cyc + 1, 13'd4799, 6'd3);
      bus_write(2'd1, 16'd3);
      push_wr(cyc + 1, 13'd0, 6'd4);
      bus_write(2'd1, 16'd4);
      bus_read(2'd0, rd);
      check("cursor_wrap", {16'd0, rd}, 32'd1);

      // Illegal tile ID, then W1C
      bus_write(2'd1, 16'd41);
      bus_read(2'd0, rd);
      check("cursor_hold_badid", {16'd0, rd}, 32'd1);
      bus_read(2'd3, rd);
      check("status_err_id", {16'd0, rd}, 32'h2);
      bus_write(2'd3, 16'h2);
      bus_read(2'd3, rd);
      check("status_clr_id", {16'd0, rd}, 32'h0);

      // Out-of-range cursor
      bus_write(2'd0, 16'd4800);
      bus_read(2'd0, rd);
      check("cursor_hold_badaddr", {16'd0, rd}, 32'd1);
      bus_read(2'd3, rd);
      check("status_err_addr", {16'd0, rd}, 32'h4);
      bus_write(2'd3, 16'h4);
      bus_read(2'd3, rd);
      check("status_clr_addr", {16'd0, rd}, 32'h0);

      // Highest legal ID
      push_wr(cyc + 1, 13'd1, 6'd40);
      bus_write(2'd1, 16'd40);
      bus_read(2'd0, rd);
      check("cursor_after_id40", {16'd0, rd}, 32'd2);

      // Illegal fill ID does not start the engine
      bus_write(2'd2, 16'd41);
      check("badfill_busy", {31'd0, busy}, 32'd0);
      bus_read(2'd3, rd);
      check("status_badfill", {16'd0, rd}, 32'h2);
      bus_write(2'd3, 16'h2);

      // Full fill with ID 11
      k = cyc + 1;
      for (int i = 0; i < 4800; i++) push_wr(k + i, 13'(i), 6'd11);
      bus_write(2'd2, 16'd11);
      check("fill_busy_start", {31'd0, busy}, 32'd1);
      bus_write(2'd1, 16'd5);
      bus_read(2'd3, rd);
      check("status_err_busy", {16'd0, rd}, 32'h9);
      bus_read(2'd2, rd);
      check("fill_id_read", {16'd0, rd}, 32'd11);
      bus_read(2'd0, rd);
      check("cursor_during_fill", {16'd0, rd}, 32'd2);
      wait_until(k + 4800);
      check("done_busy", {31'd0, busy}, 32'd1);
      check("done_we", {31'd0, tile_we}, 32'd0);
      @(posedge clk); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("fill_drained", exp_q.size(), 32'd0);
      bus_write(2'd3, 16'h8);
      bus_read(2'd3, rd);
      check("status_clr_busy", {16'd0, rd}, 32'h0);
      bus_read(2'd0, rd);
      check("cursor_after_fill", {16'd0, rd}, 32'd2);

      // Reset during a fill
      k = cyc + 1;
      for (int i = 0; i < 4800; i++) push_wr(k + i, 13'(i), 6'd9);
      bus_write(2'd2, 16'd9);
      bus_write(2'd1, 16'd3);
      wait_until(k + 2000);
      check("midfill_addr", {19'd0, tile_waddr}, 32'd2000);
      check("midfill_we", {31'd0, tile_we}, 32'd1);
      #1;
      exp_q.delete();
      reset_n = 1'b0;
      #1;
      check("async_rst_we", {31'd0, tile_we}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus_read(2'd3, rd);
      check("status_after_rst", {16'd0, rd}, 32'h0);
      bus_read(2'd0, rd);
      check("cursor_after_rst", {16'd0, rd}, 32'd0);
      check("we_after_rst", {31'd0, tile_we}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
